// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared branch-predictor types, 2-bit counter encodings and defaults
package bp_pkg;

  localparam int DEPTH_DEFAULT    = 4;
  localparam int FALLTHRU_DEFAULT = 8;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b11,
    STRONG_T  = 2'b10
  } bpState_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        pred;
  } bpEntry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// rtl/bp_inflight_fifo.sv - in-order register-array FIFO of predicted branches with flush
module bp_inflight_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  bpEntry_t                 din,
  output bpEntry_t                 dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtrNext;
  bpEntry_t      mem [DEPTH];

  assign rdPtrNext = rdPtr + PW'(pop);
  assign dout      = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      rdPtr <= rdPtrNext;
      // Flush drops everything younger than the entry being popped.
      if (flush) begin
        wrPtr <= rdPtrNext;
        count <= '0;
      end else begin
        wrPtr <= wrPtr + PW'(push);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wrPtr] <= din;
    end
  end

endmodule

// File: rtl/bp_resolve_ctrl.sv
// rtl/bp_resolve_ctrl.sv - D->M branch prediction tracking, mispredict flush/redirect
// Optional perf counters: define BP_PERF_CNT_EN.
module bp_resolve_ctrl
  import bp_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int FALLTHRU = FALLTHRU_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branchD,
  input  logic        stallD,
  input  logic        pred_takeD,
  input  logic [31:0] pcD,
  input  logic [31:0] targetD,
  input  logic        branchM,
  input  logic        actual_takeM,
  output logic        stall_req,
  output logic        mispredM,
  output logic        redirect_vld,
  output logic [31:0] redirect_pc,
  output logic        flush_req,
  output logic        upd_vld,
  output logic [31:0] upd_pc,
  output logic        upd_take,
  output logic        order_err
`ifdef BP_PERF_CNT_EN
  ,
  input  logic        perf_clr,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispred
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] count;
  logic          qEmpty;
  logic          qFull;
  logic          enq;
  logic          deq;
  bpEntry_t      head;
  bpEntry_t      newEntry;

  assign qEmpty   = (count == '0);
  assign qFull    = (count == CW'(DEPTH));
  assign newEntry = '{pc: pcD, target: targetD, pred: pred_takeD};

  // Combinational strobes are masked during reset so nothing leaks out mid-reset.
  assign stall_req = ~rst & qFull & branchD;
  assign deq       = ~rst & branchM & ~qEmpty;
  assign mispredM  = deq & (head.pred ^ actual_takeM);
  assign enq       = ~rst & branchD & ~stallD & ~stall_req & ~flush_req & ~mispredM;

  assign upd_vld  = deq;
  assign upd_pc   = head.pc;
  assign upd_take = actual_takeM;

  bp_inflight_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (enq),
    .pop  (deq),
    .flush(mispredM),
    .din  (newEntry),
    .dout (head),
    .count(count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_vld <= 1'b0;
      flush_req    <= 1'b0;
      redirect_pc  <= '0;
      order_err    <= 1'b0;
    end else begin
      redirect_vld <= mispredM;
      flush_req    <= mispredM;
      if (mispredM) begin
        redirect_pc <= actual_takeM ? head.target : head.pc + 32'(FALLTHRU);
      end
      order_err <= order_err | (branchM & qEmpty);
    end
  end

`ifdef BP_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else begin
      if (upd_vld && perf_branches != '1) begin
        perf_branches <= perf_branches + 32'd1;
      end
      if (mispredM && perf_mispred != '1) begin
        perf_mispred <= perf_mispred + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bp_resolve_ctrl.sv
// tb/tb_bp_resolve_ctrl.sv - self-checking bench for bp_resolve_ctrl (optionally BP_PERF_CNT_EN)
module tb_bp_resolve_ctrl;
  import bp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        branchD, stallD, pred_takeD, branchM, actual_takeM;
  logic [31:0] pcD, targetD;
  logic        stall_req, mispredM, redirect_vld, flush_req, upd_vld, upd_take, order_err;
  logic [31:0] redirect_pc, upd_pc;
`ifdef BP_PERF_CNT_EN
  logic        perf_clr = 1'b0;
  logic [31:0] perf_branches, perf_mispred;
`endif

  always #5 clk = ~clk;

  bp_resolve_ctrl dut (
    .clk(clk), .rst(rst),
    .branchD(branchD), .stallD(stallD), .pred_takeD(pred_takeD),
    .pcD(pcD), .targetD(targetD),
    .branchM(branchM), .actual_takeM(actual_takeM),
    .stall_req(stall_req), .mispredM(mispredM),
    .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .flush_req(flush_req), .upd_vld(upd_vld), .upd_pc(upd_pc),
    .upd_take(upd_take), .order_err(order_err)
`ifdef BP_PERF_CNT_EN
    , .perf_clr(perf_clr), .perf_branches(perf_branches), .perf_mispred(perf_mispred)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        bD, sD, pT;
    logic [31:0] pc, tg;
    logic        bM, aT;
    logic        eStall, eMisp, eUpd;
  } vec_t;

  vec_t        vecs[$];
  bpEntry_t    sbQ[$];
  logic [31:0] redirQ[$];
  bit          expRedir = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic addv(logic bD, logic sD, logic pT, logic [31:0] pc, logic [31:0] tg,
                      logic bM, logic aT, logic eS, logic eM, logic eU);
    vec_t v;
    v = '{bD: bD, sD: sD, pT: pT, pc: pc, tg: tg, bM: bM, aT: aT,
          eStall: eS, eMisp: eM, eUpd: eU};
    vecs.push_back(v);
  endtask

  task automatic setIn(logic bD, logic sD, logic pT, logic [31:0] pc, logic [31:0] tg,
                       logic bM, logic aT);
    branchD = bD; stallD = sD; pred_takeD = pT; pcD = pc; targetD = tg;
    branchM = bM; actual_takeM = aT;
  endtask

  task automatic runVec(vec_t v, int idx);
    bit       nextRedir = 0;
    bpEntry_t h;
    @(negedge clk);
    chk($sformatf("redirect_vld[%0d]", idx), {31'd0, redirect_vld}, {31'd0, expRedir});
    chk($sformatf("flush_req[%0d]", idx), {31'd0, flush_req}, {31'd0, expRedir});
    if (expRedir && redirQ.size() > 0)
      chk($sformatf("redirect_pc[%0d]", idx), redirect_pc, redirQ.pop_front());
    setIn(v.bD, v.sD, v.pT, v.pc, v.tg, v.bM, v.aT);
    #1;
    chk($sformatf("stall_req[%0d]", idx), {31'd0, stall_req}, {31'd0, v.eStall});
    chk($sformatf("mispredM[%0d]", idx), {31'd0, mispredM}, {31'd0, v.eMisp});
    chk($sformatf("upd_vld[%0d]", idx), {31'd0, upd_vld}, {31'd0, v.eUpd});
    chk($sformatf("order_err[%0d]", idx), {31'd0, order_err}, 32'd0);
    if (v.eUpd && sbQ.size() > 0) begin
      chk($sformatf("upd_pc[%0d]", idx), upd_pc, sbQ[0].pc);
      chk($sformatf("upd_take[%0d]", idx), {31'd0, upd_take}, {31'd0, v.aT});
    end
    if (v.bM && sbQ.size() > 0) begin
      h = sbQ.pop_front();
      if (v.eMisp) begin
        redirQ.push_back(v.aT ? h.target : h.pc + 32'd8);
        sbQ.delete();
        nextRedir = 1;
      end
    end
    if (v.bD && !v.sD && !v.eStall && !v.eMisp && !expRedir)
      sbQ.push_back('{pc: v.pc, target: v.tg, pred: v.pT});
    expRedir = nextRedir;
  endtask

  initial begin
    rst = 1'b1;
    setIn(0, 0, 0, 32'd0, 32'd0, 0, 0);

    //    bD sD pT pc        tg        bM aT  stall misp upd
    // correct taken prediction
    addv(1, 0, 1, 32'h100, 32'h200, 0, 0,   0, 0, 0);
    addv(0, 0, 0, 32'h0,   32'h0,   1, 1,   0, 0, 1);
    addv(0, 0, 0, 32'h0,   32'h0,   0, 0,   0, 0, 0);
    // taken prediction, resolves not-taken -> fall-through redirect; flush blocks D
    addv(1, 0, 1, 32'h100, 32'h200, 0, 0,   0, 0, 0);
    addv(0, 0, 0, 32'h0,   32'h0,   1, 0,   0, 1, 1);
    addv(1, 0, 0, 32'h999, 32'h998, 0, 0,   0, 0, 0);
    // fill to DEPTH, 5th branch stalls until one cycle after a dequeue
    addv(1, 0, 0, 32'h10,  32'h20,  0, 0,   0, 0, 0);
    addv(1, 0, 1, 32'h30,  32'h40,  0, 0,   0, 0, 0);
    addv(1, 0, 0, 32'h50,  32'h60,  0, 0,   0, 0, 0);
    addv(1, 0, 1, 32'h70,  32'h80,  0, 0,   0, 0, 0);
    addv(1, 0, 0, 32'h90,  32'hA0,  0, 0,   1, 0, 0);
    addv(1, 0, 0, 32'h90,  32'hA0,  1, 0,   1, 0, 1);
    addv(1, 0, 0, 32'h90,  32'hA0,  0, 0,   0, 0, 0);
    addv(0, 0, 0, 32'h0,   32'h0,   1, 1,   0, 0, 1);
    addv(0, 0, 0, 32'h0,   32'h0,   1, 0,   0, 0, 1);
    addv(0, 0, 0, 32'h0,   32'h0,   1, 1,   0, 0, 1);
    addv(0, 0, 0, 32'h0,   32'h0,   1, 0,   0, 0, 1);
    // A mispredicts taken while C sits in D: B and C discarded
    addv(1, 0, 0, 32'h300, 32'h400, 0, 0,   0, 0, 0);
    addv(1, 0, 1, 32'h500, 32'h600, 0, 0,   0, 0, 0);
    addv(1, 0, 1, 32'h700, 32'h780, 1, 1,   0, 1, 1);
    addv(1, 0, 1, 32'h710, 32'h790, 0, 0,   0, 0, 0);
    addv(1, 0, 1, 32'h800, 32'h900, 0, 0,   0, 0, 0);
    addv(0, 0, 0, 32'h0,   32'h0,   1, 1,   0, 0, 1);
    // stallD holds the D branch out of the queue
    addv(1, 1, 1, 32'hAAA, 32'hBBB, 0, 0,   0, 0, 0);
    addv(0, 0, 0, 32'h0,   32'h0,   0, 0,   0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset stall_req", {31'd0, stall_req}, 32'd0);
    chk("reset upd_vld", {31'd0, upd_vld}, 32'd0);
    chk("reset redirect_vld", {31'd0, redirect_vld}, 32'd0);
    chk("reset flush_req", {31'd0, flush_req}, 32'd0);
    chk("reset redirect_pc", redirect_pc, 32'd0);
    chk("reset order_err", {31'd0, order_err}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) runVec(vecs[i], i);

    // branchM with empty queue: sticky order_err, no update, cleared by reset
    @(negedge clk);
    setIn(0, 0, 0, 32'h0, 32'h0, 1, 1);
    #1;
    chk("empty upd_vld", {31'd0, upd_vld}, 32'd0);
    chk("empty mispredM", {31'd0, mispredM}, 32'd0);
    @(negedge clk);
    chk("order_err set", {31'd0, order_err}, 32'd1);
    setIn(0, 0, 0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    chk("order_err held", {31'd0, order_err}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("order_err cleared", {31'd0, order_err}, 32'd0);
    rst = 1'b0;

    // reset on a mispredict cycle suppresses every pulse
    @(negedge clk);
    setIn(1, 0, 1, 32'h1000, 32'h2000, 0, 0);
    @(negedge clk);
    setIn(0, 0, 0, 32'h0, 32'h0, 1, 0);
    rst = 1'b1;
    #1;
    chk("rst mispredM", {31'd0, mispredM}, 32'd0);
    chk("rst upd_vld", {31'd0, upd_vld}, 32'd0);
    @(negedge clk);
    chk("rst redirect_vld", {31'd0, redirect_vld}, 32'd0);
    chk("rst flush_req", {31'd0, flush_req}, 32'd0);
    chk("rst redirect_pc", redirect_pc, 32'd0);
    rst = 1'b0;
    setIn(0, 0, 0, 32'h0, 32'h0, 1, 1);
    #1;
    chk("post-rst queue empty", {31'd0, upd_vld}, 32'd0);
    @(negedge clk);
    setIn(0, 0, 0, 32'h0, 32'h0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

`ifdef BP_PERF_CNT_EN
    @(negedge clk);
    chk("perf_branches reset", perf_branches, 32'd0);
    chk("perf_mispred reset", perf_mispred, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      setIn(1, 0, 1, 32'h4000 + 32'(i * 16), 32'h8000, 0, 0);
      @(negedge clk);
      setIn(0, 0, 0, 32'h0, 32'h0, 1, (i % 4) != 0);
      @(negedge clk);
      setIn(0, 0, 0, 32'h0, 32'h0, 0, 0);
    end
    @(negedge clk);
    chk("perf_branches", perf_branches, 32'd10);
    chk("perf_mispred", perf_mispred, 32'd3);
    setIn(1, 0, 1, 32'h5000, 32'h6000, 0, 0);
    @(negedge clk);
    setIn(0, 0, 0, 32'h0, 32'h0, 1, 0);
    perf_clr = 1'b1;
    @(negedge clk);
    setIn(0, 0, 0, 32'h0, 32'h0, 0, 0);
    perf_clr = 1'b0;
    chk("perf_branches clr", perf_branches, 32'd0);
    chk("perf_mispred clr", perf_mispred, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
